// File: rtl/io_input_port.sv
// Memory-mapped input port: synchronized, debounced switches/buttons with sticky press flags and an event counter.
// Latency: pin to level 2+DEBOUNCE_CYCLES clk cycles; register read data and rd_valid one cycle after rd_en.
// Backpressure: none; one read is accepted every cycle. Optional IO_IRQ_EN macro adds a registered irq output.
module io_input_port #(
    parameter int          NUM_SW          = 8,
    parameter int          NUM_BTN         = 4,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               rd_en,
    input  logic [31:0]        rd_addr,
    output logic [31:0]        rd_data,
    output logic               rd_valid
`ifdef IO_IRQ_EN
    ,
    output logic               irq
`endif
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0]  sw_meta, sw_sync, sw_lvl, sw_acc;
    logic [NUM_BTN-1:0] btn_meta, btn_sync, btn_lvl, btn_acc, btn_rise;
    logic [CW-1:0]      sw_cnt  [NUM_SW];
    logic [CW-1:0]      btn_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] pending;
    logic [15:0]        evt_count;
    logic [5:0]         rise_cnt;
    logic               addr_hit;
    logic               evt_rd;
    logic [31:0]        rd_mux;
    logic               unused_addr_bits;

    // Byte offset within a word does not affect decode.
    assign unused_addr_bits = ^rd_addr[1:0];

    // Two-flop synchronizers for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // Per-bit acceptance: a differing bit whose counter has reached its final count takes the new level this edge.
    always_comb begin
        sw_acc   = '0;
        btn_acc  = '0;
        rise_cnt = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            sw_acc[i] = (sw_sync[i] != sw_lvl[i]) && (sw_cnt[i] == CNT_MAX);
        end
        for (int i = 0; i < NUM_BTN; i++) begin
            btn_acc[i] = (btn_sync[i] != btn_lvl[i]) && (btn_cnt[i] == CNT_MAX);
        end
        btn_rise = btn_acc & btn_sync;
        for (int i = 0; i < NUM_BTN; i++) begin
            rise_cnt = rise_cnt + 6'(btn_rise[i]);
        end
    end

    // Switch debounce: count consecutive differing cycles, restart whenever the input agrees with the level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_lvl <= '0;
            for (int i = 0; i < NUM_SW; i++) sw_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (sw_sync[i] == sw_lvl[i]) begin
                    sw_cnt[i] <= '0;
                end else if (sw_acc[i]) begin
                    sw_cnt[i] <= '0;
                    sw_lvl[i] <= sw_sync[i];
                end else begin
                    sw_cnt[i] <= sw_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Button debounce, same scheme as the switches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_lvl <= '0;
            for (int i = 0; i < NUM_BTN; i++) btn_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_sync[i] == btn_lvl[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_acc[i]) begin
                    btn_cnt[i]  <= '0;
                    btn_lvl[i] <= btn_sync[i];
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Register window decode; a BTN_EVT read returns pre-edge flags.
    always_comb begin
        addr_hit = (rd_addr[31:4] == BASE_ADDR[31:4]);
        rd_mux   = '0;
        if (addr_hit) begin
            case (rd_addr[3:2])
                2'd0:    rd_mux = 32'(sw_lvl);
                2'd1:    rd_mux = 32'(btn_lvl);
                2'd2:    rd_mux = 32'(pending);
                default: rd_mux = {16'b0, evt_count};
            endcase
        end
        evt_rd = rd_en && addr_hit && (rd_addr[3:2] == 2'd2);
    end

    // Sticky press flags and wrapping press counter; a press on the clearing edge survives the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending   <= '0;
            evt_count <= '0;
        end else begin
            pending   <= (evt_rd ? '0 : pending) | btn_rise;
            evt_count <= evt_count + 16'(rise_cnt);
        end
    end

    // Read response register: data holds until the next read, valid pulses once per read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

`ifdef IO_IRQ_EN
    // Level interrupt while any press flag is pending.
    always_ff @(posedge clk) begin
        if (!reset) irq <= 1'b0;
        else        irq <= |pending;
    end
`endif

endmodule

// File: tb/tb_io_input_port.sv
module tb_io_input_port;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    logic [7:0]  f_sw;
    logic [3:0]  f_btn;
    logic        f_rd_en;
    logic [31:0] f_rd_addr;
    logic [31:0] f_rd_data;
    logic        f_rd_valid;
`ifdef IO_IRQ_EN
    logic        irq;
    logic        f_irq;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    io_input_port #(
        .NUM_SW(8), .NUM_BTN(4), .DEBOUNCE_CYCLES(4), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .sw(sw), .btn(btn),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
`ifdef IO_IRQ_EN
        , .irq(irq)
`endif
    );

    // Second instance with the shortest debounce, used for the counter wrap run.
    io_input_port #(
        .NUM_SW(8), .NUM_BTN(4), .DEBOUNCE_CYCLES(2), .BASE_ADDR(BASE)
    ) dut_fast (
        .clk(clk), .reset(reset), .sw(f_sw), .btn(f_btn),
        .rd_en(f_rd_en), .rd_addr(f_rd_addr), .rd_data(f_rd_data), .rd_valid(f_rd_valid)
`ifdef IO_IRQ_EN
        , .irq(f_irq)
`endif
    );

    // Single read on the main instance; called at a negedge, returns at the next negedge.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic vld);
        rd_en   = 1'b1;
        rd_addr = addr;
        @(negedge clk);
        data    = rd_data;
        vld     = rd_valid;
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        @(negedge clk);
        reset   = 1'b0;
        rd_en   = 1'b1;
        rd_addr = BASE;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_valid: got %b want 0", rd_valid);
        end
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        rd_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            do_read(BASE + 32'(a * 4), d, v);
            checks++;
            if (d !== 32'h0 || v !== 1'b1) begin
                errors++;
                $display("FAIL reset_reg%0d: got data=%h valid=%b want 0/1", a, d, v);
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic        v;
        sw = 8'h01;
        repeat (3) @(negedge clk);
        sw = 8'h00;
        repeat (8) @(negedge clk);
        do_read(BASE, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL glitch_ignored: got %h want 0", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        v;
        sw      = 8'hA5;
        rd_en   = 1'b1;
        rd_addr = BASE;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_valid_%0d: got %b want 1", j, rd_valid);
            end
            if (j == 6) begin
                checks++;
                if (rd_data !== 32'h0) begin
                    errors++;
                    $display("FAIL sw_too_early: got %h want 0", rd_data);
                end
            end
            if (j == 7) begin
                checks++;
                if (rd_data !== 32'h0000_00A5) begin
                    errors++;
                    $display("FAIL sw_level: got %h want 000000a5", rd_data);
                end
            end
        end
        rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL idle_hold: got valid=%b data=%h want 0/000000a5", rd_valid, rd_data);
        end
        do_read(BASE + 32'd3, d, v);
        checks++;
        if (d !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL byte_offset_ignored: got %h want 000000a5", d);
        end
    endtask

    task automatic test_button();
        logic [31:0] d;
        logic        v;
        btn = 4'h4;
        repeat (9) @(negedge clk);
        do_read(BASE + 32'h4, d, v);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL btn_level: got %h want 4", d);
        end
        btn = 4'h0;
        repeat (10) @(negedge clk);
        do_read(BASE + 32'h8, d, v);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL btn_evt_first: got %h want 4", d);
        end
        do_read(BASE + 32'h8, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL btn_evt_cleared: got %h want 0", d);
        end
        do_read(BASE + 32'hC, d, v);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL evt_count_one: got %h want 1", d);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic        v;
        btn = 4'h2;
        repeat (5) @(negedge clk);
        do_read(BASE + 32'h8, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL collide_read: got %h want 0", d);
        end
        do_read(BASE + 32'h8, d, v);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL collide_kept: got %h want 2", d);
        end
        btn = 4'h0;
        repeat (10) @(negedge clk);
        do_read(BASE + 32'hC, d, v);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL evt_count_two: got %h want 2", d);
        end
    endtask

`ifdef IO_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        logic        v;
        btn = 4'h8;
        repeat (6) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_before: got %b want 0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got %b want 1", irq);
        end
        do_read(BASE + 32'h8, d, v);
        checks++;
        if (d !== 32'h8 || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_read: got data=%h irq=%b want 8/1", d, irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_drop: got %b want 0", irq);
        end
        btn = 4'h0;
        repeat (10) @(negedge clk);
    endtask
`endif

    task automatic test_unmapped();
        logic [31:0] d;
        logic        v;
        do_read(BASE + 32'h10, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_0x10: got data=%h valid=%b want 0/1", d, v);
        end
        do_read(32'h0000_0200, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_0x200: got data=%h valid=%b want 0/1", d, v);
        end
    endtask

    task automatic test_evt_wrap();
        // 16384 presses of all four buttons = 65536 events, then one more.
        for (int k = 0; k < 16384; k++) begin
            f_btn = 4'hF;
            repeat (2) @(negedge clk);
            f_btn = 4'h0;
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        f_rd_en   = 1'b1;
        f_rd_addr = BASE + 32'hC;
        @(negedge clk);
        f_rd_en = 1'b0;
        checks++;
        if (f_rd_data !== 32'h0 || f_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_zero: got data=%h valid=%b want 0/1", f_rd_data, f_rd_valid);
        end
        f_btn = 4'h1;
        repeat (4) @(negedge clk);
        f_btn = 4'h0;
        repeat (8) @(negedge clk);
        f_rd_en = 1'b1;
        @(negedge clk);
        f_rd_en = 1'b0;
        checks++;
        if (f_rd_data !== 32'h1) begin
            errors++;
            $display("FAIL wrap_one: got %h want 1", f_rd_data);
        end
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        sw        = '0;
        btn       = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        f_sw      = '0;
        f_btn     = '0;
        f_rd_en   = 1'b0;
        f_rd_addr = '0;
        test_reset();
        test_glitch();
        test_back_to_back();
        test_button();
        test_collision();
`ifdef IO_IRQ_EN
        test_irq();
`endif
        test_unmapped();
        test_evt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
Memory-mapped input peripheral; the input-side counterpart of the seven-segment output port. Samples board switches and push-buttons in the board clock domain, synchronizes and debounces them, and latches button-press events into sticky flags. Exposes four read-only registers to the CPU load path with a fixed 1-cycle read latency.

Parameters:
NUM_SW, 8, number of slide switches (1..32)
NUM_BTN, 4, number of push-buttons (1..32)
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level (>=2)
BASE_ADDR, 32'h0000_0100, word-aligned base of the 16-byte register window

Ports:
clk  input  1  board clock
reset  input  1  synchronous, active-low reset
sw  input  NUM_SW  raw switch pins, asynchronous
btn  input  NUM_BTN  raw button pins, asynchronous, 1 = pressed
rd_en  input  1  single-cycle read strobe (mem_load qualified by en_exe_pulse, in clk domain)
rd_addr  input  32  byte address of the read
rd_data  output  32  read data
rd_valid  output  1  high exactly one cycle after an accepted rd_en
irq  output  1  present only with IO_IRQ_EN

Behaviour:
- Reset: clk edge with reset==0. Clears synchronizers, debounce counters, stable levels, pending flags, event count; rd_data=0, rd_valid=0, irq=0. Reset asserted mid-read: rd_valid=0 next cycle, no pending flags cleared.
- Synchronizer: two flops per pin; inputs used only after the second flop.
- Debounce, per bit: stable value S, counter C. If synced != S then C increments; when C reaches DEBOUNCE_CYCLES-1 while still differing, S <= synced and C <= 0. If synced == S, C <= 0. Pin-to-S latency = 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press event: button S transitions 0->1 -> pending[i] <= 1 on the same edge S updates; evt_count += number of bits rising that cycle (popcount), 16-bit, wraps 0xFFFF->0x0000. Releases generate no event.
- Register map, offset from BASE_ADDR:
  +0x0 SW_LEVEL: debounced switches, zero-extended.
  +0x4 BTN_LEVEL: debounced buttons, zero-extended.
  +0x8 BTN_EVT: pending flags, read-to-clear.
  +0xC EVT_COUNT: {16'b0, evt_count}; not cleared by read.
- Address decode uses rd_addr[31:4]==BASE_ADDR[31:4] and rd_addr[3:2]; rd_addr[1:0] ignored. Unmapped address: rd_data=0, rd_valid still pulses, no side effects.
- Read timing: rd_en sampled at edge N; rd_data/rd_valid valid after edge N+1. rd_data holds until the next accepted read. rd_valid is 0 in every cycle without a preceding rd_en.
- BTN_EVT read returns the flags as of edge N; flags clear at edge N. A new event on the same edge as the clear wins: that bit stays 1 and is not included in the returned value.
- Back-to-back rd_en on consecutive cycles: every read is serviced, one per cycle, in order.

Optional Feature:
IO_IRQ_EN: defined -> irq port exists; registered irq = |pending, updates one cycle after pending changes and drops one cycle after a clearing BTN_EVT read (unless a new event sets it). Undefined -> no irq port and no irq logic; polling only.

Test Plan:
- DEBOUNCE_CYCLES=4: reset low 3 cycles -> rd_valid=0, reads of all four registers return 0.
- sw=8'hA5 held -> SW_LEVEL read returns 32'h0000_00A5 no earlier than 6 cycles after the pin change; a 3-cycle pulse sw[0]=1 never changes SW_LEVEL.
- btn[2] pressed 10 cycles then released -> BTN_LEVEL returns 4 while held; BTN_EVT returns 32'h4 once, then a second read returns 0; EVT_COUNT=1.
- btn[1] rising edge lands on the same edge as a BTN_EVT read -> that read returns 0 for bit 1; the next read returns 32'h2.
- 65537 presses of btn[0] (forced via small debounce) -> EVT_COUNT reads 1; rd_addr=BASE_ADDR+0x10 -> rd_data=0, rd_valid=1.
- IO_IRQ_EN defined: btn[3] press -> irq=1 within 1 cycle of the pending flag setting; BTN_EVT read -> irq=0 one cycle later.
